// File: rtl/inst_fetch_buffer.sv
// inst_fetch_buffer: 3-wide circular instruction queue between fetch and decode.
module inst_fetch_buffer #(
  parameter int size  = 32,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic [2:0]                 fetch_valid_i,
  output logic                       fetch_ready_o,
  input  logic [size-1:0]            instruction_i_0,
  input  logic [size-1:0]            instruction_i_1,
  input  logic [size-1:0]            instruction_i_2,
  input  logic [size-1:0]            pc_i_0,
  input  logic [size-1:0]            pc_i_1,
  input  logic [size-1:0]            pc_i_2,
  input  logic [size-1:0]            imm_i_0,
  input  logic [size-1:0]            imm_i_1,
  input  logic [size-1:0]            imm_i_2,
  input  logic                       branch_prediction_i_0,
  input  logic                       branch_prediction_i_1,
  input  logic                       branch_prediction_i_2,
  output logic [2:0]                 decode_valid_o,
  input  logic                       decode_ready_i,
  output logic [size-1:0]            instruction_o_0,
  output logic [size-1:0]            instruction_o_1,
  output logic [size-1:0]            instruction_o_2,
  output logic [size-1:0]            pc_o_0,
  output logic [size-1:0]            pc_o_1,
  output logic [size-1:0]            pc_o_2,
  output logic [size-1:0]            imm_o_0,
  output logic [size-1:0]            imm_o_1,
  output logic [size-1:0]            imm_o_2,
  output logic                       branch_prediction_o_0,
  output logic                       branch_prediction_o_1,
  output logic                       branch_prediction_o_2,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       empty_o,
  output logic                       full_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef struct packed {
    logic [size-1:0] ins;
    logic [size-1:0] pc;
    logic [size-1:0] imm;
    logic            bp;
  } entry_t;
  entry_t         mem [DEPTH];
  entry_t         in_e [3];
  entry_t         out_e [3];
  logic [AW-1:0]  wa [3];
  logic [AW-1:0]  head, tail;
  logic [CW-1:0]  count;
  logic           push, pop;
  logic [1:0]     n, m;
  assign fetch_ready_o  = count <= CW'(DEPTH - 3);
  assign decode_valid_o = {count > CW'(2), count > CW'(1), count > CW'(0)};
  assign count_o        = count;
  assign empty_o        = count == '0;
  assign full_o         = count == CW'(DEPTH);
  always_comb begin
    in_e[0] = '{instruction_i_0, pc_i_0, imm_i_0, branch_prediction_i_0};
    in_e[1] = '{instruction_i_1, pc_i_1, imm_i_1, branch_prediction_i_1};
    in_e[2] = '{instruction_i_2, pc_i_2, imm_i_2, branch_prediction_i_2};
    push = fetch_ready_o && !flush;
    pop  = decode_ready_i && !flush;
    n = push ? 2'(fetch_valid_i[0]) + 2'(fetch_valid_i[1]) + 2'(fetch_valid_i[2]) : 2'd0;
    m = pop ? (count > CW'(3) ? 2'd3 : count[1:0]) : 2'd0;
    // valid lanes pack densely from tail regardless of mask shape
    wa[0] = tail;
    wa[1] = tail + AW'(fetch_valid_i[0]);
    wa[2] = tail + AW'(fetch_valid_i[0]) + AW'(fetch_valid_i[1]);
    for (int k = 0; k < 3; k++)
      out_e[k] = decode_valid_o[k] ? mem[head + AW'(k)] : '0;
  end
  always_ff @(posedge clk)
    for (int k = 0; k < 3; k++)
      if (push && fetch_valid_i[k]) mem[wa[k]] <= in_e[k];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + AW'(m);
      tail  <= tail + AW'(n);
      count <= count + CW'(n) - CW'(m);
    end
  assign instruction_o_0       = out_e[0].ins;
  assign instruction_o_1       = out_e[1].ins;
  assign instruction_o_2       = out_e[2].ins;
  assign pc_o_0                = out_e[0].pc;
  assign pc_o_1                = out_e[1].pc;
  assign pc_o_2                = out_e[2].pc;
  assign imm_o_0               = out_e[0].imm;
  assign imm_o_1               = out_e[1].imm;
  assign imm_o_2               = out_e[2].imm;
  assign branch_prediction_o_0 = out_e[0].bp;
  assign branch_prediction_o_1 = out_e[1].bp;
  assign branch_prediction_o_2 = out_e[2].bp;
endmodule

// File: tb/tb_inst_fetch_buffer.sv
// tb_inst_fetch_buffer: directed scoreboard bench for inst_fetch_buffer.
module tb_inst_fetch_buffer;
  logic        clk = 0, reset = 0, flush = 0, decode_ready_i = 0;
  logic [2:0]  fetch_valid_i = 0, decode_valid_o;
  logic        fetch_ready_o, empty_o, full_o;
  logic [31:0] instruction_i_0, instruction_i_1, instruction_i_2;
  logic [31:0] pc_i_0, pc_i_1, pc_i_2, imm_i_0, imm_i_1, imm_i_2;
  logic        branch_prediction_i_0, branch_prediction_i_1, branch_prediction_i_2;
  logic [31:0] instruction_o_0, instruction_o_1, instruction_o_2;
  logic [31:0] pc_o_0, pc_o_1, pc_o_2, imm_o_0, imm_o_1, imm_o_2;
  logic        branch_prediction_o_0, branch_prediction_o_1, branch_prediction_o_2;
  logic [3:0]  count_o;
  int checks = 0, errors = 0;
  typedef struct {logic [31:0] ins, pc, imm; logic bp;} ent_t;
  ent_t sb[$];
  logic [31:0] io [3], po [3], mo [3];
  logic        bo [3];
  assign io = '{instruction_o_0, instruction_o_1, instruction_o_2};
  assign po = '{pc_o_0, pc_o_1, pc_o_2};
  assign mo = '{imm_o_0, imm_o_1, imm_o_2};
  assign bo = '{branch_prediction_o_0, branch_prediction_o_1, branch_prediction_o_2};
  always #5 clk = ~clk;
  inst_fetch_buffer #(.size(32), .DEPTH(8)) dut (
    .clk(clk), .reset(reset), .flush(flush), .fetch_valid_i(fetch_valid_i),
    .fetch_ready_o(fetch_ready_o),
    .instruction_i_0(instruction_i_0), .instruction_i_1(instruction_i_1), .instruction_i_2(instruction_i_2),
    .pc_i_0(pc_i_0), .pc_i_1(pc_i_1), .pc_i_2(pc_i_2),
    .imm_i_0(imm_i_0), .imm_i_1(imm_i_1), .imm_i_2(imm_i_2),
    .branch_prediction_i_0(branch_prediction_i_0), .branch_prediction_i_1(branch_prediction_i_1),
    .branch_prediction_i_2(branch_prediction_i_2),
    .decode_valid_o(decode_valid_o), .decode_ready_i(decode_ready_i),
    .instruction_o_0(instruction_o_0), .instruction_o_1(instruction_o_1), .instruction_o_2(instruction_o_2),
    .pc_o_0(pc_o_0), .pc_o_1(pc_o_1), .pc_o_2(pc_o_2),
    .imm_o_0(imm_o_0), .imm_o_1(imm_o_1), .imm_o_2(imm_o_2),
    .branch_prediction_o_0(branch_prediction_o_0), .branch_prediction_o_1(branch_prediction_o_1),
    .branch_prediction_o_2(branch_prediction_o_2),
    .count_o(count_o), .empty_o(empty_o), .full_o(full_o)
  );
  function automatic ent_t mk(input logic [31:0] pc);
    mk = '{32'hDEAD_0000 ^ pc, pc, ~pc, pc[3]};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic check_all();
    ent_t e;
    int sz = sb.size();
    chk("count", 32'(count_o), 32'(sz));
    chk("empty", 32'(empty_o), 32'(sz == 0));
    chk("full", 32'(full_o), 32'(sz == 8));
    chk("fetch_ready", 32'(fetch_ready_o), 32'(sz <= 5));
    chk("decode_valid", 32'(decode_valid_o), 32'({sz > 2, sz > 1, sz > 0}));
    for (int k = 0; k < 3; k++) begin
      e = k < sz ? sb[k] : '{32'h0, 32'h0, 32'h0, 1'b0};
      chk($sformatf("ins%0d", k), io[k], e.ins);
      chk($sformatf("pc%0d", k), po[k], e.pc);
      chk($sformatf("imm%0d", k), mo[k], e.imm);
      chk($sformatf("bp%0d", k), 32'(bo[k]), 32'(e.bp));
    end
  endtask
  task automatic cyc(input logic [2:0] v, input logic rdy, input logic fl, input logic [31:0] pc0);
    int m;
    bit acc;
    ent_t l0, l1, l2;
    l0 = mk(pc0); l1 = mk(pc0 + 4); l2 = mk(pc0 + 8);
    @(negedge clk);
    fetch_valid_i = v; decode_ready_i = rdy; flush = fl;
    {instruction_i_0, pc_i_0, imm_i_0, branch_prediction_i_0} = {l0.ins, l0.pc, l0.imm, l0.bp};
    {instruction_i_1, pc_i_1, imm_i_1, branch_prediction_i_1} = {l1.ins, l1.pc, l1.imm, l1.bp};
    {instruction_i_2, pc_i_2, imm_i_2, branch_prediction_i_2} = {l2.ins, l2.pc, l2.imm, l2.bp};
    acc = sb.size() <= 5;
    @(posedge clk);
    #1;
    if (fl) sb.delete();
    else begin
      m = rdy ? (sb.size() < 3 ? sb.size() : 3) : 0;
      repeat (m) void'(sb.pop_front());
      if (acc) begin
        if (v[0]) sb.push_back(l0);
        if (v[1]) sb.push_back(l1);
        if (v[2]) sb.push_back(l2);
      end
    end
    fetch_valid_i = 0; decode_ready_i = 0; flush = 0;
    check_all();
  endtask
  initial begin
    {instruction_i_0, instruction_i_1, instruction_i_2} = '0;
    {pc_i_0, pc_i_1, pc_i_2, imm_i_0, imm_i_1, imm_i_2} = '0;
    {branch_prediction_i_0, branch_prediction_i_1, branch_prediction_i_2} = '0;
    #2 check_all();
    @(negedge clk) reset = 1;
    cyc(3'b111, 0, 0, 32'h0);
    cyc(3'b111, 0, 0, 32'h100);
    cyc(3'b111, 0, 0, 32'h200);
    cyc(3'b000, 1, 0, 32'h0);
    cyc(3'b000, 1, 0, 32'h0);
    cyc(3'b111, 0, 0, 32'h500);
    cyc(3'b111, 0, 0, 32'h600);
    cyc(3'b000, 1, 0, 32'h0);
    cyc(3'b000, 1, 0, 32'h0);
    cyc(3'b011, 0, 0, 32'h300);
    cyc(3'b011, 1, 0, 32'h400);
    cyc(3'b000, 1, 0, 32'h0);
    cyc(3'b101, 0, 0, 32'h700);
    cyc(3'b010, 0, 0, 32'h800);
    cyc(3'b110, 0, 0, 32'h900);
    cyc(3'b111, 0, 0, 32'hA00);
    cyc(3'b111, 1, 0, 32'hB00);
    cyc(3'b111, 1, 1, 32'hC00);
    cyc(3'b111, 0, 0, 32'hD00);
    cyc(3'b001, 0, 0, 32'hE00);
    @(negedge clk);
    #2 reset = 0;
    #1;
    chk("async_count", 32'(count_o), 32'h0);
    chk("async_empty", 32'(empty_o), 32'h1);
    sb.delete();
    check_all();
    @(negedge clk) reset = 1;
    cyc(3'b111, 0, 0, 32'hF00);
    cyc(3'b000, 1, 0, 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
